// File: rtl/i2c_dom_target_pkg.sv
// Shared I2C defines for the domain-tagged register target.
// Holds the FSM state encoding, the register index map, the bit-counter
// width and the read-side register multiplexer.
package i2c_dom_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_e;

  // Counts sampled data bits 0..8 within a byte.
  localparam int BIT_CNT_W = 4;

  localparam logic [1:0] REG_CTRL0 = 2'd0;
  localparam logic [1:0] REG_CTRL1 = 2'd1;
  localparam logic [1:0] REG_STAT0 = 2'd2;
  localparam logic [1:0] REG_STAT1 = 2'd3;

  function automatic logic [7:0] reg_mux(input logic [1:0] idx,
                                         input logic [7:0] c0, input logic [7:0] c1,
                                         input logic [7:0] s0, input logic [7:0] s1);
    logic [7:0] r;
    case (idx)
      REG_CTRL0: r = c0;
      REG_CTRL1: r = c1;
      REG_STAT0: r = s0;
      default:   r = s1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_dom_target_bus_sync.sv
// i2c_bus_sync: brings the asynchronous pad scl/sda into the clk domain
// and derives bus events from the synchronized values only.
// Ports:
//   clk, rst          - system clock, async active-high reset
//   scl_i, sda_i      - raw pad inputs
//   sda_s             - synchronized sda level
//   scl_rise/scl_fall - one-clk strobes on synchronized scl edges
//   start_det         - sda fell while scl high
//   stop_det          - sda rose while scl high
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_hist_q, scl_hist_d;
  logic       sda_hist_q, sda_hist_d;
  logic       scl_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_hist_d = scl_sync_q[1];
    sda_hist_d = sda_sync_q[1];
  end

  // Reset to the idle-bus level so leaving reset never looks like a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  =  scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s &  scl_hist_q;
  // scl must be high in both samples so an scl edge never counts as a condition.
  assign start_det = scl_s & scl_hist_q & ~sda_s &  sda_hist_q;
  assign stop_det  = scl_s & scl_hist_q &  sda_s & ~sda_hist_q;

endmodule

// File: rtl/i2c_dom_target.sv
// i2c_dom_target: 7-bit I2C register target with four byte registers
// (ctrl0/ctrl1 writable, stat0/stat1 read-only) and a security-domain tag
// captured at START and reported with each write.
// Ports:
//   clk, rst          - system clock, async active-high reset
//   domain            - domain of the bus segment, latched at START
//   sl_addr           - own 7-bit address
//   scl_i, sda_i      - pad inputs; sda_oe=1 pulls SDA low
//   ctrl0, ctrl1      - writable register contents
//   stat0, stat1      - read-only register inputs
//   wr_pulse/wr_idx/wr_domain - write strobe, index and domain of last write
//   busy              - addressed, from address ACK until STOP / IDLE
module i2c_dom_target
  import i2c_dom_target_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       domain,
  input  logic [6:0] sl_addr,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] ctrl0,
  output logic [7:0] ctrl1,
  input  logic [7:0] stat0,
  input  logic [7:0] stat1,
  output logic       wr_pulse,
  output logic [1:0] wr_idx,
  output logic       wr_domain,
  output logic       busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]           sh_q, sh_d;      // received byte
  logic [7:0]           tx_q, tx_d;      // byte being sent, MSB = next bit
  logic                 rw_q, rw_d;
  logic [1:0]           ptr_q, ptr_d;
  logic                 dom_q, dom_d;
  logic                 mack_q, mack_d;  // master ACK bit, 0 = ACK
  logic                 sda_oe_q, sda_oe_d;
  logic                 busy_q, busy_d;
  logic                 wr_pulse_q, wr_pulse_d;
  logic [1:0]           wr_idx_q, wr_idx_d;
  logic                 wr_domain_q, wr_domain_d;
  logic [7:0]           ctrl0_q, ctrl0_d;
  logic [7:0]           ctrl1_q, ctrl1_d;

  logic byte_in;
  assign byte_in = (cnt_q == BIT_CNT_W'(8));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    ptr_d       = ptr_q;
    dom_d       = dom_q;
    mack_d      = mack_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_pulse_d  = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_domain_d = wr_domain_q;
    ctrl0_d     = ctrl0_q;
    ctrl1_d     = ctrl1_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      dom_d   = domain;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && !byte_in) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + BIT_CNT_W'(1);
          end
          // ACK is driven from the fall after bit 8.
          if (scl_fall && byte_in) begin
            cnt_d = '0;
            case (state_q)
              ST_ADDR: begin
                if (sh_q[7:1] == sl_addr) begin
                  state_d  = ST_ADDR_ACK;
                  rw_d     = sh_q[0];
                  sda_oe_d = 1'b1;
                  busy_d   = 1'b1;
                end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                end
              end
              ST_PTR: begin
                state_d  = ST_PTR_ACK;
                sda_oe_d = 1'b1;
              end
              default: begin
                state_d  = ST_WDATA_ACK;
                sda_oe_d = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              // Read byte is frozen here; later stat changes do not leak in.
              tx_d     = reg_mux(ptr_q, ctrl0_q, ctrl1_q, stat0, stat1);
              sda_oe_d = ~tx_d[7];
              state_d  = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_PTR;
            end
          end
        end
        ST_PTR_ACK: begin
          if (scl_fall) begin
            ptr_d    = sh_q[1:0];
            sda_oe_d = 1'b0;
            state_d  = ST_WDATA;
          end
        end
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d    = 1'b0;
            wr_pulse_d  = 1'b1;
            wr_idx_d    = ptr_q;
            wr_domain_d = dom_q;
            if (ptr_q == REG_CTRL0) ctrl0_d = sh_q;
            if (ptr_q == REG_CTRL1) ctrl1_d = sh_q;
            ptr_d   = ptr_q + 2'd1;
            state_d = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (scl_rise && !byte_in) cnt_d = cnt_q + BIT_CNT_W'(1);
          if (scl_fall) begin
            if (byte_in) begin
              cnt_d    = '0;
              sda_oe_d = 1'b0;
              state_d  = ST_RDATA_ACK;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) mack_d = sda_s;
          if (scl_fall) begin
            if (!mack_q) begin
              ptr_d    = ptr_q + 2'd1;
              tx_d     = reg_mux(ptr_d, ctrl0_q, ctrl1_q, stat0, stat1);
              sda_oe_d = ~tx_d[7];
              state_d  = ST_RDATA;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      ptr_q       <= 2'd0;
      dom_q       <= 1'b0;
      mack_q      <= 1'b1;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_idx_q    <= 2'd0;
      wr_domain_q <= 1'b0;
      ctrl0_q     <= 8'h00;
      ctrl1_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      dom_q       <= dom_d;
      mack_q      <= mack_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_idx_q    <= wr_idx_d;
      wr_domain_q <= wr_domain_d;
      ctrl0_q     <= ctrl0_d;
      ctrl1_q     <= ctrl1_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_idx    = wr_idx_q;
  assign wr_domain = wr_domain_q;
  assign ctrl0     = ctrl0_q;
  assign ctrl1     = ctrl1_q;

endmodule

// File: tb/tb_i2c_dom_target.sv
// Bench for i2c_dom_target: bit-banged I2C master, a table of write
// transactions with hand-derived expectations, directed corner sequences,
// and a randomized phase checked against a register-map model.
module tb_i2c_dom_target;

  localparam int Q = 60;  // quarter bit period, ns

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       domain = 1'b0;
  logic [6:0] sl_addr = 7'h10;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] stat0 = 8'h00;
  logic [7:0] stat1 = 8'h00;
  logic       sda_oe, wr_pulse, wr_domain, busy;
  logic [7:0] ctrl0, ctrl1;
  logic [1:0] wr_idx;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_dom_target dut (
    .clk       (clk),
    .rst       (rst),
    .domain    (domain),
    .sl_addr   (sl_addr),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .ctrl0     (ctrl0),
    .ctrl1     (ctrl1),
    .stat0     (stat0),
    .stat1     (stat1),
    .wr_pulse  (wr_pulse),
    .wr_idx    (wr_idx),
    .wr_domain (wr_domain),
    .busy      (busy)
  );

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  always @(posedge clk) begin
    if (wr_pulse) pulse_cnt <= pulse_cnt + 1;
    if (sda_oe)   oe_cnt    <= oe_cnt + 1;
    if (busy)     busy_cnt  <= busy_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bus_start;
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(Q);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;    #(Q);
    scl_m = 1'b1; #(Q);
    r = sda_bus;  #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  // ack = 1 when the target acknowledged; tog_at flips domain before that bit.
  task automatic wr_byte(input logic [7:0] b, input int tog_at, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      if (7 - i == tog_at) domain = ~domain;
      bus_bit(b[i], r);
    end
    bus_bit(1'b1, r);
    ack = ~r;
  endtask

  // mack = 1 sends ACK; poke_at overwrites stat0 before that bit.
  task automatic rd_byte(input logic mack, input int poke_at, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      if (7 - i == poke_at) stat0 = 8'hFF;
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(~mack, r);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sda_oe"},    sda_oe,    1'b0);
    chk({tag, "_busy"},      busy,      1'b0);
    chk({tag, "_wr_pulse"},  wr_pulse,  1'b0);
    chk({tag, "_wr_idx"},    wr_idx,    2'd0);
    chk({tag, "_wr_domain"}, wr_domain, 1'b0);
    chk({tag, "_ctrl0"},     ctrl0,     8'h00);
    chk({tag, "_ctrl1"},     ctrl1,     8'h00);
  endtask

  typedef struct {
    logic       dom;
    logic [7:0] abyte;
    logic [7:0] pbyte;
    int         nd;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       e_ack;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
    int         e_pul;
    logic [1:0] e_idx;
    logic       e_wd;
  } vec_t;

  vec_t vec [6];

  // Model state for the random phase.
  logic [7:0] m_c0, m_c1;
  int         m_ptr;
  logic [1:0] m_idx;
  logic       m_wd;

  function automatic logic [7:0] mreg(input int p);
    case (p)
      0: return m_c0;
      1: return m_c1;
      2: return stat0;
      default: return stat1;
    endcase
  endfunction

  initial begin
    logic       a, dm, acks_ok;
    logic [7:0] d, pb;
    logic [6:0] wa;
    int         p0, o0, b0, n, kind;

    // domain, addr byte, ptr byte, nd, d0, d1, ack, ctrl0, ctrl1, pulses, idx, wdom
    vec[0] = '{1'b0, 8'h20, 8'h01, 1, 8'hA5, 8'h00, 1'b1, 8'h00, 8'hA5, 1, 2'd1, 1'b0};
    vec[1] = '{1'b0, 8'h20, 8'h03, 2, 8'h11, 8'h22, 1'b1, 8'h22, 8'hA5, 2, 2'd0, 1'b0};
    vec[2] = '{1'b0, 8'h22, 8'h00, 1, 8'h77, 8'h00, 1'b0, 8'h22, 8'hA5, 0, 2'd0, 1'b0};
    vec[3] = '{1'b1, 8'h20, 8'h00, 1, 8'h5A, 8'h00, 1'b1, 8'h5A, 8'hA5, 1, 2'd0, 1'b1};
    vec[4] = '{1'b0, 8'h20, 8'h02, 2, 8'h99, 8'h88, 1'b1, 8'h5A, 8'hA5, 2, 2'd3, 1'b0};
    vec[5] = '{1'b1, 8'h20, 8'h00, 2, 8'h01, 8'h02, 1'b1, 8'h01, 8'h02, 2, 2'd1, 1'b1};

    #23;
    rst = 1'b0;
    #(Q);
    chk_reset("rst0");

    // Fresh pointer is 0: a bare read returns ctrl0, not the stat registers.
    stat0 = 8'hC3; stat1 = 8'h3C;
    bus_start;
    wr_byte(8'h21, -1, a);
    chk("rd_ptr0_ack", a, 1'b1);
    rd_byte(1'b0, -1, d);
    chk("rd_ptr0_data", d, 8'h00);
    bus_stop;

    // Table of write transactions.
    for (int i = 0; i < 6; i++) begin
      p0 = pulse_cnt; o0 = oe_cnt; b0 = busy_cnt;
      acks_ok = 1'b1;
      domain = vec[i].dom;
      bus_start;
      wr_byte(vec[i].abyte, -1, a);
      chk("tbl_addr_ack", a, vec[i].e_ack);
      if (a) begin
        wr_byte(vec[i].pbyte, -1, a);
        acks_ok &= a;
        wr_byte(vec[i].d0, -1, a);
        acks_ok &= a;
        if (vec[i].nd > 1) begin
          wr_byte(vec[i].d1, -1, a);
          acks_ok &= a;
        end
        chk("tbl_data_acks", acks_ok, 1'b1);
      end
      bus_stop;
      chk("tbl_ctrl0", ctrl0, vec[i].e_c0);
      chk("tbl_ctrl1", ctrl1, vec[i].e_c1);
      chk("tbl_pulses", pulse_cnt - p0, vec[i].e_pul);
      chk("tbl_wr_idx", wr_idx, vec[i].e_idx);
      chk("tbl_wr_domain", wr_domain, vec[i].e_wd);
      chk("tbl_busy_end", busy, 1'b0);
      chk("tbl_oe_seen", (oe_cnt - o0) > 0, vec[i].e_ack);
      chk("tbl_busy_seen", (busy_cnt - b0) > 0, vec[i].e_ack);
    end

    // Pointer write, repeated START, two-byte read; stat0 poked mid-byte.
    stat0 = 8'h34; stat1 = 8'h56; domain = 1'b0;
    bus_start;
    wr_byte(8'h20, -1, a); chk("rd_w_addr_ack", a, 1'b1);
    wr_byte(8'h02, -1, a); chk("rd_ptr_ack", a, 1'b1);
    bus_start;
    wr_byte(8'h21, -1, a); chk("rd_r_addr_ack", a, 1'b1);
    chk("rd_busy", busy, 1'b1);
    rd_byte(1'b1, 4, d);   chk("rd_byte0", d, 8'h34);
    rd_byte(1'b0, -1, d);  chk("rd_byte1", d, 8'h56);
    chk("rd_nack_release", sda_oe, 1'b0);
    chk("rd_nack_busy", busy, 1'b0);
    bus_stop;

    // STOP after four bits of a data byte: nothing written.
    p0 = pulse_cnt;
    bus_start;
    wr_byte(8'h20, -1, a); chk("stp_addr_ack", a, 1'b1);
    wr_byte(8'h00, -1, a); chk("stp_ptr_ack", a, 1'b1);
    for (int i = 0; i < 4; i++) bus_bit(i[0], a);
    bus_stop;
    chk("stp_pulses", pulse_cnt - p0, 0);
    chk("stp_ctrl0", ctrl0, 8'h01);
    chk("stp_busy", busy, 1'b0);

    // Domain flips mid-byte: the write keeps the START-time domain.
    p0 = pulse_cnt;
    domain = 1'b0;
    bus_start;
    wr_byte(8'h20, -1, a);
    wr_byte(8'h01, -1, a);
    wr_byte(8'h3C, 3, a);  chk("dom_data_ack", a, 1'b1);
    bus_stop;
    chk("dom_wr_domain", wr_domain, 1'b0);
    chk("dom_ctrl1", ctrl1, 8'h3C);
    chk("dom_wr_idx", wr_idx, 2'd1);
    chk("dom_pulses", pulse_cnt - p0, 1);
    domain = 1'b0;

    // Reset asserted while the address ACK is being driven.
    bus_start;
    for (int i = 7; i >= 0; i--) begin
      pb = 8'h20;
      bus_bit(pb[i], a);
    end
    sda_m = 1'b1;
    #(Q);
    chk("ack_driven", sda_oe, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_release", sda_oe, 1'b0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    #6;
    #(Q);
    rst = 1'b0;
    #(Q);
    chk_reset("rst1");

    // Randomized traffic against the register-map model.
    m_c0 = 8'h00; m_c1 = 8'h00; m_ptr = 0; m_idx = 2'd0; m_wd = 1'b0;
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 3);
      p0 = pulse_cnt; o0 = oe_cnt;
      if (kind <= 1) begin
        dm = 1'($urandom_range(0, 1));
        pb = 8'($urandom);
        domain = dm;
        bus_start;
        wr_byte(8'h20, -1, a); chk("r_w_addr_ack", a, 1'b1);
        wr_byte(pb, -1, a);    chk("r_ptr_ack", a, 1'b1);
        m_ptr = int'(pb[1:0]);
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          d = 8'($urandom);
          wr_byte(d, 1 + j, a);  // domain wiggles mid-byte
          chk("r_data_ack", a, 1'b1);
          if (m_ptr == 0) m_c0 = d;
          else if (m_ptr == 1) m_c1 = d;
          m_idx = 2'(m_ptr);
          m_wd  = dm;
          m_ptr = (m_ptr + 1) % 4;
        end
        bus_stop;
        chk("r_ctrl0", ctrl0, m_c0);
        chk("r_ctrl1", ctrl1, m_c1);
        chk("r_wr_idx", wr_idx, m_idx);
        chk("r_wr_domain", wr_domain, m_wd);
        chk("r_pulses", pulse_cnt - p0, n);
      end else if (kind == 2) begin
        stat0 = 8'($urandom);
        stat1 = 8'($urandom);
        domain = 1'($urandom_range(0, 1));
        bus_start;
        if ($urandom_range(0, 1) == 1) begin
          pb = 8'($urandom);
          wr_byte(8'h20, -1, a); chk("r_rp_addr_ack", a, 1'b1);
          wr_byte(pb, -1, a);    chk("r_rp_ptr_ack", a, 1'b1);
          m_ptr = int'(pb[1:0]);
          bus_start;
        end
        wr_byte(8'h21, -1, a); chk("r_r_addr_ack", a, 1'b1);
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          rd_byte(j != n - 1, -1, d);
          chk("r_rd_data", d, mreg(m_ptr));
          if (j != n - 1) m_ptr = (m_ptr + 1) % 4;
        end
        chk("r_rd_busy_end", busy, 1'b0);
        bus_stop;
        chk("r_rd_pulses", pulse_cnt - p0, 0);
      end else begin
        wa = 7'($urandom);
        if (wa == 7'h10) wa = 7'h11;
        bus_start;
        wr_byte({wa, 1'($urandom_range(0, 1))}, -1, a);
        chk("r_bad_nack", a, 1'b0);
        bus_stop;
        chk("r_bad_oe", oe_cnt - o0, 0);
        chk("r_bad_pulses", pulse_cnt - p0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
